// File: rtl/arp_reply_queue_pkg.sv
// ARP reply queue: shared constants, FSM states and frame byte mapper.
// Frame layout offsets are byte indices into the Ethernet frame.
package arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] ARP_HTYPE     = 16'h0001;
  localparam logic [15:0] ARP_PTYPE     = 16'h0800;
  localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
  localparam logic [7:0]  ARP_HLEN      = 8'h06;
  localparam logic [7:0]  ARP_PLEN      = 8'h04;

  localparam int REQ_BYTES    = 10;
  localparam int ARP_BODY_END = 42;

  localparam int OFF_DST_MAC = 0;
  localparam int OFF_SRC_MAC = 6;
  localparam int OFF_ETYPE   = 12;
  localparam int OFF_SHA     = 22;
  localparam int OFF_SPA     = 28;
  localparam int OFF_THA     = 32;
  localparam int OFF_TPA     = 38;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_ABORT
  } arp_state_e;

  // rec = {requester MAC, requester IP}; returns 0 past the ARP body
  function automatic logic [7:0] frame_byte(
    input logic [7:0]  idx,
    input logic [79:0] rec,
    input logic [47:0] lmac,
    input logic [31:0] lip
  );
    logic [79:0] hdr;
    logic [7:0]  b;
    int i;
    int k;
    hdr = {ETHERTYPE_ARP, ARP_HTYPE, ARP_PTYPE,
           ARP_HLEN, ARP_PLEN, ARP_OP_REPLY};
    i = int'(idx);
    b = 8'h00;
    if (i < OFF_SRC_MAC) begin
      k = i - OFF_DST_MAC;
      b = rec[8*(9-k) +: 8];
    end else if (i < OFF_ETYPE) begin
      k = i - OFF_SRC_MAC;
      b = lmac[8*(5-k) +: 8];
    end else if (i < OFF_SHA) begin
      k = i - OFF_ETYPE;
      b = hdr[8*(9-k) +: 8];
    end else if (i < OFF_SPA) begin
      k = i - OFF_SHA;
      b = lmac[8*(5-k) +: 8];
    end else if (i < OFF_THA) begin
      k = i - OFF_SPA;
      b = lip[8*(3-k) +: 8];
    end else if (i < OFF_TPA) begin
      k = i - OFF_THA;
      b = rec[8*(9-k) +: 8];
    end else if (i < ARP_BODY_END) begin
      k = i - OFF_TPA;
      b = rec[8*(3-k) +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/arp_reply_queue_fifo.sv
// Pending ARP request record FIFO.
// Push while full is accepted when a pop happens in the same cycle.
module arp_req_fifo
  import arp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign level   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // record storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/arp_reply_queue.sv
// Queued ARP reply frame generator for the Ethernet TX path.
// Optional ARP_DROP_COUNT_EN enables the saturating drop counter.
module arp_reply_queue
  import arp_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter int          MIN_LEN = 60,
  parameter logic [31:0] IP      = 32'hC0A80702,
  parameter logic [47:0] MAC     = 48'h125555000130
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] arp_bus,
  input  logic [8:0]  address_set,
  output logic        arp_reply_req,
  input  logic        strobe,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [79:0] stage_rec, stage_nxt, head;
  logic [3:0]  stage_cnt, cnt_nxt;
  logic        mal, mal_nxt;
  logic        commit, pop, full, empty, req_nxt;
  logic [LW-1:0] level;
  logic [47:0] loc_mac, snap_mac;
  logic [31:0] loc_ip, snap_ip;
  logic [79:0] snap_rec;
  logic [3:0]  cfg_ptr;
  arp_state_e  state, state_nxt;
  logic        strobe_q, rise, idx_v;
  logic [7:0]  n, idx, byte_sel;

  // staging view including a byte written this cycle
  always_comb begin
    stage_nxt = stage_rec;
    cnt_nxt   = stage_cnt;
    mal_nxt   = mal;
    if (arp_bus[8]) begin
      if (stage_cnt < 4'(REQ_BYTES)) begin
        stage_nxt[8*(9-int'(stage_cnt)) +: 8] = arp_bus[7:0];
        cnt_nxt = stage_cnt + 4'd1;
      end else begin
        mal_nxt = 1'b1;
      end
    end
  end

  assign commit = arp_bus[9] && arp_bus[10] && !mal_nxt &&
                  (cnt_nxt == 4'(REQ_BYTES)) && (!full || pop);

  // staging register, cleared by every end-of-request strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_rec <= '0;
      stage_cnt <= '0;
      mal       <= 1'b0;
    end else begin
      stage_rec <= stage_nxt;
      stage_cnt <= arp_bus[9] ? 4'd0 : cnt_nxt;
      mal       <= arp_bus[9] ? 1'b0 : mal_nxt;
    end
  end

  arp_req_fifo #(.DEPTH(DEPTH), .W(80)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (commit),
    .pop   (pop),
    .wdata (stage_nxt),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign req_nxt = commit || (pop ? (level != LW'(1)) : !empty);

  // runtime rewrite of local MAC/IP, one byte per write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loc_mac <= MAC;
      loc_ip  <= IP;
      cfg_ptr <= '0;
    end else if (address_set[8]) begin
      if (cfg_ptr < 4'd6)
        loc_mac[8*(5-int'(cfg_ptr)) +: 8] <= address_set[7:0];
      else
        loc_ip[8*(9-int'(cfg_ptr)) +: 8] <= address_set[7:0];
      cfg_ptr <= (cfg_ptr == 4'd9) ? 4'd0 : cfg_ptr + 4'd1;
    end
  end

  assign rise = strobe && !strobe_q;
  assign busy = (state != ST_IDLE);

  // frame FSM next state and pop decision
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rise && !empty) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (!strobe) begin
          if (n >= 8'(ARP_BODY_END)) begin
            state_nxt = ST_IDLE;
            pop       = 1'b1;
          end else begin
            state_nxt = ST_ABORT;
          end
        end
      end
      ST_ABORT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign byte_sel = (int'(idx) >= MIN_LEN) ? 8'h00 :
                    frame_byte(idx, snap_rec, snap_mac, snap_ip);

  // state, byte counter, snapshot and two-stage output pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      strobe_q      <= 1'b0;
      n             <= '0;
      idx           <= '0;
      idx_v         <= 1'b0;
      data_out      <= '0;
      snap_rec      <= '0;
      snap_mac      <= '0;
      snap_ip       <= '0;
      arp_reply_req <= 1'b0;
    end else begin
      state         <= state_nxt;
      strobe_q      <= strobe;
      arp_reply_req <= req_nxt;
      data_out      <= idx_v ? byte_sel : 8'h00;
      idx_v         <= 1'b0;
      if (state == ST_IDLE && state_nxt == ST_SEND) begin
        snap_rec <= head;
        snap_mac <= loc_mac;
        snap_ip  <= loc_ip;
        idx      <= 8'd0;
        idx_v    <= 1'b1;
        n        <= 8'd1;
      end else if (state == ST_SEND && strobe) begin
        idx   <= n;
        idx_v <= 1'b1;
        if (n != 8'hFF) n <= n + 8'd1;
      end
    end
  end

`ifdef ARP_DROP_COUNT_EN
  logic       drop;
  logic [7:0] drops;

  assign drop     = arp_bus[9] && !commit;
  assign drop_cnt = drops;

  // saturating count of discarded requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drops <= '0;
    else if (drop && drops != 8'hFF)
      drops <= drops + 8'd1;
  end
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_arp_reply_queue.sv
// Directed self-checking bench for arp_reply_queue.
// Expected frames are built from a bench-side frame map.
module tb_arp_reply_queue;

  localparam int DEPTH = 4;
  localparam int MIN_LEN = 60;
  localparam logic [47:0] RST_MAC = 48'h125555000130;
  localparam logic [31:0] RST_IP  = 32'hC0A80702;
`ifdef ARP_DROP_COUNT_EN
  localparam logic [7:0] EXP_D1 = 8'd1;
  localparam logic [7:0] EXP_D2 = 8'd2;
`else
  localparam logic [7:0] EXP_D1 = 8'd0;
  localparam logic [7:0] EXP_D2 = 8'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] arp_bus;
  logic [8:0]  address_set;
  logic        arp_reply_req;
  logic        strobe;
  logic [7:0]  data_out;
  logic        busy;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  int busy_seen;
  bit cfg_during = 1'b0;
  logic [7:0] cap [0:299];
  logic [7:0] cfg_bytes [0:9];
  logic [7:0] orv;

  always #5 clk = ~clk;

  arp_reply_queue #(.DEPTH(DEPTH), .MIN_LEN(MIN_LEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .arp_bus       (arp_bus),
    .address_set   (address_set),
    .arp_reply_req (arp_reply_req),
    .strobe        (strobe),
    .data_out      (data_out),
    .busy          (busy),
    .drop_cnt      (drop_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    arp_bus = '0;
    address_set = '0;
    strobe = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic send_req(input logic [47:0] mac, input logic [31:0] ip,
                          input logic ok, input int nb);
    logic [79:0] rec;
    rec = {mac, ip};
    for (int i = 0; i < nb; i++) begin
      arp_bus = {2'b00, 1'b1, rec[8*(9-i) +: 8]};
      tick;
    end
    arp_bus = {ok, 1'b1, 1'b0, 8'h00};
    tick;
    arp_bus = '0;
  endtask

  task automatic run_frame(input int len);
    busy_seen = 0;
    strobe = 1'b1;
    for (int j = 1; j <= len + 3; j++) begin
      tick;
      if (busy) busy_seen++;
      if (j >= 2 && j - 2 < len) cap[j-2] = data_out;
      if (cfg_during)
        address_set = (j >= 3 && j < 13) ? {1'b1, cfg_bytes[j-3]} : 9'h0;
      if (j == len) strobe = 1'b0;
    end
    address_set = '0;
  endtask

  function automatic logic [7:0] exp_byte(input int i,
    input logic [47:0] rm, input logic [31:0] ri,
    input logic [47:0] lm, input logic [31:0] li);
    logic [7:0] fx [0:9];
    fx = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08,
           8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
    if (i < 6)  return rm[8*(5-i) +: 8];
    if (i < 12) return lm[8*(11-i) +: 8];
    if (i < 22) return fx[i-12];
    if (i < 28) return lm[8*(27-i) +: 8];
    if (i < 32) return li[8*(31-i) +: 8];
    if (i < 38) return rm[8*(37-i) +: 8];
    if (i < 42) return ri[8*(41-i) +: 8];
    return 8'h00;
  endfunction

  task automatic check_frame(input string tag, input int len,
    input logic [47:0] rm, input logic [31:0] ri,
    input logic [47:0] lm, input logic [31:0] li);
    for (int i = 0; i < len; i++)
      chk($sformatf("%s_b%0d", tag, i), 48'(cap[i]),
          48'(exp_byte(i, rm, ri, lm, li)));
  endtask

  task automatic check_silent(input string tag, input int len);
    orv = 8'h00;
    for (int i = 0; i < len; i++) orv = orv | cap[i];
    chk({tag, "_busy"}, 48'(busy_seen), 48'd0);
    chk({tag, "_dout"}, 48'(orv), 48'd0);
  endtask

  initial begin
    rst = 1'b1;
    arp_bus = '0;
    address_set = '0;
    strobe = 1'b0;
    tick;
    tick;
    chk("rst_req", 48'(arp_reply_req), 48'd0);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_dout", 48'(data_out), 48'd0);
    chk("rst_drop", 48'(drop_cnt), 48'd0);
    rst = 1'b0;
    tick;

    // single request, full 60-byte frame
    send_req(48'h001122334455, 32'hC0A80709, 1'b1, 10);
    chk("t1_req_up", 48'(arp_reply_req), 48'd1);
    run_frame(60);
    check_frame("t1", 60, 48'h001122334455, 32'hC0A80709, RST_MAC, RST_IP);
    chk("t1_req_dn", 48'(arp_reply_req), 48'd0);
    chk("t1_busy_dn", 48'(busy), 48'd0);
    chk("t1_dout_idle", 48'(data_out), 48'd0);
    run_frame(10);
    check_silent("t1_empty", 10);

    // rejected requests, then staging must be clean again
    do_reset;
    send_req(48'h0A0B0C0D0E0F, 32'h01020304, 1'b0, 10);
    chk("t2_req_nok", 48'(arp_reply_req), 48'd0);
    send_req(48'h0A0B0C0D0E0F, 32'h01020304, 1'b1, 9);
    chk("t2_req_short", 48'(arp_reply_req), 48'd0);
    chk("t2_drop", 48'(drop_cnt), 48'(EXP_D2));
    send_req(48'h0A0B0C0D0E0F, 32'h01020304, 1'b1, 10);
    chk("t2_req_ok", 48'(arp_reply_req), 48'd1);

    // overflow: DEPTH+1 requests, then DEPTH frames in order
    do_reset;
    for (int k = 0; k <= DEPTH; k++)
      send_req(48'h0A0000000000 | 48'(k), 32'h0A000100 + 32'(k), 1'b1, 10);
    chk("t3_drop", 48'(drop_cnt), 48'(EXP_D1));
    for (int k = 0; k < DEPTH; k++) begin
      run_frame(k == 0 ? 42 : 60);
      check_frame($sformatf("t3_f%0d", k), k == 0 ? 42 : 60,
                  48'h0A0000000000 | 48'(k), 32'h0A000100 + 32'(k),
                  RST_MAC, RST_IP);
    end
    chk("t3_req_dn", 48'(arp_reply_req), 48'd0);

    // aborts retain the entry; long strobe pads with zeros
    do_reset;
    send_req(48'hA1A2A3A4A5A6, 32'hC0A80763, 1'b1, 10);
    run_frame(20);
    check_frame("t4_a20", 20, 48'hA1A2A3A4A5A6, 32'hC0A80763, RST_MAC, RST_IP);
    chk("t4_req_a20", 48'(arp_reply_req), 48'd1);
    chk("t4_busy_a20", 48'(busy), 48'd0);
    run_frame(41);
    chk("t4_req_a41", 48'(arp_reply_req), 48'd1);
    run_frame(64);
    check_frame("t4_full", 64, 48'hA1A2A3A4A5A6, 32'hC0A80763, RST_MAC, RST_IP);
    chk("t4_req_dn", 48'(arp_reply_req), 48'd0);

    // address rewrite mid-frame takes effect on the next frame
    do_reset;
    send_req(48'h111111111111, 32'h0A000001, 1'b1, 10);
    send_req(48'h222222222222, 32'h0A000002, 1'b1, 10);
    cfg_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h01, 8'h0A, 8'h00, 8'h00, 8'h05};
    cfg_during = 1'b1;
    run_frame(60);
    cfg_during = 1'b0;
    check_frame("t5_old", 60, 48'h111111111111, 32'h0A000001, RST_MAC, RST_IP);
    run_frame(60);
    check_frame("t5_new", 60, 48'h222222222222, 32'h0A000002,
                48'h020000000001, 32'h0A000005);

    // reset mid-frame flushes everything
    do_reset;
    for (int k = 0; k < 3; k++)
      send_req(48'h3300000000AA + 48'(k), 32'h0A0000AA, 1'b1, 10);
    strobe = 1'b1;
    repeat (10) tick;
    rst = 1'b1;
    #1;
    chk("t6_dout", 48'(data_out), 48'd0);
    chk("t6_busy", 48'(busy), 48'd0);
    chk("t6_req", 48'(arp_reply_req), 48'd0);
    strobe = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    tick;
    run_frame(50);
    check_silent("t6_after", 50);
    chk("t6_req_after", 48'(arp_reply_req), 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
